// File: rtl/arb2_wb_ctrl.sv
// Two-requester round-robin arbiter that owns a shared write-back path with one registered output beat.
// Optional macro ARB2_BURST_LIMIT_EN forces a grant to be released after MAX_BEATS beats when the other side waits.
module arb2_wb_ctrl #(
    parameter int MAX_BEATS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        last0,
    input  logic        last1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic        sel,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_src,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t state, state_next;
    logic   ptr, ptr_next;
    logic   slot_free, ack_any, cur_last, limit_hit;

    if (MAX_BEATS < 2 || MAX_BEATS > 15) begin : g_max_beats_range
        $error("arb2_wb_ctrl: MAX_BEATS must be within 2..15");
    end

    assign gnt0      = (state == GRANT0);
    assign gnt1      = (state == GRANT1);
    assign sel       = (state == GRANT1);
    assign slot_free = !out_valid || out_ready;
    assign ack0      = gnt0 && req0 && slot_free;
    assign ack1      = gnt1 && req1 && slot_free;
    assign ack_any   = ack0 || ack1;
    assign cur_last  = sel ? last1 : last0;

`ifdef ARB2_BURST_LIMIT_EN
    localparam logic [3:0] LIMIT = 4'(MAX_BEATS);

    logic [3:0] beat_cnt;
    logic       other_req;

    assign other_req = sel ? req0 : req1;
    // Count saturates at LIMIT, so a long burst with nobody waiting can still be cut once the other side shows up.
    assign limit_hit = ack_any && (beat_cnt >= LIMIT - 4'd1) && other_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= 4'd0;
        end else if (state_next != state) begin
            beat_cnt <= 4'd0;
        end else if (ack_any && (beat_cnt != LIMIT)) begin
            beat_cnt <= beat_cnt + 4'd1;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Grants always pass through IDLE, which gives the one-cycle arbitration latency and a clean burst boundary.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_next = ptr ? GRANT1 : GRANT0;
                end else if (req0) begin
                    state_next = GRANT0;
                end else if (req1) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (ack_any && (cur_last || limit_hit)) begin
                    state_next = IDLE;
                    ptr_next   = !sel;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output slot: a new beat may replace the one being drained in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_src   <= 1'b0;
        end else if (ack_any) begin
            out_valid <= 1'b1;
            out_data  <= sel ? data1 : data0;
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
